// File: rtl/pbvi_iter_ctrl.sv
// Iteration sequencer for the PBVI value-backup pipeline: pulses each backup stage in
// order, counts iterations until convergence or the limit, and traps hung stages.
module pbvi_iter_ctrl #(
  parameter int N_STAGE = 4,
  parameter int ITER_W  = 8,
  parameter int TIMEOUT = 64,
  localparam int STG_W  = (N_STAGE > 1) ? $clog2(N_STAGE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ITER_W-1:0]  max_iter,
  input  logic [N_STAGE-1:0] stage_done,
  input  logic               converged,
  output logic [N_STAGE-1:0] stage_en,
  output logic               busy,
  output logic               done,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               err,
  output logic [STG_W-1:0]   err_stage
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(N_STAGE - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 2);
  localparam logic [ITER_W-1:0] ITER_MAX   = {ITER_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_FINISH,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic [STG_W-1:0]  err_stage_q, err_stage_d;
  logic [ITER_W:0]   iter_inc;
  logic              limit_hit;

  assign iter_inc  = {1'b0, iter_q} + 1'b1;
  assign limit_hit = (iter_inc == {1'b0, limit_q});

  // Handshake: stage_en is a one-cycle request to the current stage; that stage
  // answers with a one-cycle stage_done pulse in any later cycle. Only the bit of the
  // stage being waited on is honoured, and only while waiting.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    wd_d        = wd_q;
    limit_d     = limit_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
    err_stage_d = err_stage_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            limit_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
            iter_d  = '0;
            stage_d = '0;
            conv_d  = 1'b0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the watchdog's last cycle still counts.
          if (stage_done[stage_q]) begin
            if (stage_q != LAST_STAGE) begin
              stage_d = stage_q + 1'b1;
              state_d = S_ISSUE;
            end else begin
              conv_d  = converged;
              state_d = S_CHECK;
            end
          end else if (wd_q == WD_LAST) begin
            err_stage_d = stage_q;
            state_d     = S_ERR;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (iter_q != ITER_MAX) iter_d = iter_inc[ITER_W-1:0];
          if (conv_q || limit_hit) begin
            state_d = S_FINISH;
          end else begin
            stage_d = '0;
            state_d = S_ISSUE;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      wd_q        <= '0;
      limit_q     <= ITER_W'(1);
      iter_q      <= '0;
      conv_q      <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      wd_q        <= wd_d;
      limit_q     <= limit_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign stage_en  = (state_q == S_ISSUE) ? (N_STAGE'(1) << stage_q) : '0;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_FINISH);
  assign err       = (state_q == S_ERR);
  assign iter_cnt  = iter_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Bench for pbvi_iter_ctrl: each run's expected per-cycle outputs are derived from the
// stage latencies it will apply, then compared against the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_pbvi_iter_ctrl;
  localparam int N_STAGE = 4;
  localparam int ITER_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int MAXC    = 1024;
  localparam int W       = N_STAGE + 5 + ITER_W;

  logic               clk = 1'b0;
  logic               rst_n, start, abort, converged;
  logic [ITER_W-1:0]  max_iter;
  logic [N_STAGE-1:0] stage_done, stage_en;
  logic               busy, done, err;
  logic [ITER_W-1:0]  iter_cnt;
  logic [1:0]         err_stage;

  pbvi_iter_ctrl #(.N_STAGE(N_STAGE), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_iter(max_iter),
    .stage_done(stage_done), .converged(converged), .stage_en(stage_en), .busy(busy),
    .done(done), .iter_cnt(iter_cnt), .err(err), .err_stage(err_stage)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected timeline (offset 0 = cycle in which start is driven) and stimulus tables.
  logic [N_STAGE-1:0] e_en[MAXC], d_done[MAXC], wait_mask[MAXC];
  logic               e_busy[MAXC], e_done[MAXC], e_err[MAXC], is_chk[MAXC];
  logic               d_conv[MAXC], conv_fix[MAXC];
  logic [1:0]         e_estg[MAXC];
  logic [ITER_W-1:0]  e_iter[MAXC];

  // ---------------- driver ----------------
  // lim: max_iter; conv: iteration whose last stage reports converged (0 = never);
  // hang_*: stage that never answers; slow_*: stage answering at TIMEOUT-1;
  // kill_off: offset of abort (or reset when kill_rst), 0 = none.
  task automatic run_case(input int lim, input int conv, input int lat_lo, input int lat_hi,
                          input int hang_it, input int hang_s, input int slow_it, input int slow_s,
                          input int kill_off, input bit kill_rst, input bit noisy);
    int c, l, len, lim_eff, cnt;
    bit stop, killed;
    logic [W-1:0] w;
    logic [N_STAGE-1:0] nz;
    for (int o = 0; o < MAXC; o++) begin
      e_en[o] = '0; e_busy[o] = 0; e_done[o] = 0; e_err[o] = 0; is_chk[o] = 0;
      e_estg[o] = '0; e_iter[o] = '0; d_done[o] = '0; wait_mask[o] = '0;
      d_conv[o] = 0; conv_fix[o] = 0;
    end
    lim_eff = (lim == 0) ? 1 : lim;
    c = 1; stop = 0; len = 0;
    for (int it = 1; !stop; it++) begin
      for (int s = 0; s < N_STAGE && !stop; s++) begin
        e_en[c]   = N_STAGE'(1) << s;
        e_busy[c] = 1;
        l = $urandom_range(lat_hi, lat_lo);
        if (it == slow_it && s == slow_s) l = TIMEOUT - 1;
        if (it == hang_it && s == hang_s) begin
          for (int o = c + 1; o < c + TIMEOUT; o++) begin
            e_busy[o] = 1; wait_mask[o] = N_STAGE'(1) << s;
          end
          for (int o = c + TIMEOUT; o < c + TIMEOUT + 3; o++) begin
            e_err[o] = 1; e_estg[o] = 2'(s);
          end
          len = c + TIMEOUT + 3;
          stop = 1;
        end else begin
          for (int o = c + 1; o <= c + l; o++) begin
            e_busy[o] = 1; wait_mask[o] = N_STAGE'(1) << s;
          end
          d_done[c+l] = N_STAGE'(1) << s;
          if (s == N_STAGE - 1) begin
            conv_fix[c+l] = 1; d_conv[c+l] = (it == conv);
          end
          c = c + l + 1;
        end
      end
      if (!stop) begin
        e_busy[c] = 1; is_chk[c] = 1;
        if (it == conv || it == lim_eff) begin
          e_done[c+1] = 1; len = c + 3; stop = 1;
        end else begin
          c = c + 1;
        end
      end
    end
    killed = (kill_off > 0) && (kill_off < len - 2);
    if (killed) begin
      for (int o = kill_off + 1; o < MAXC; o++) begin
        e_en[o] = '0; e_busy[o] = 0; e_done[o] = 0; e_err[o] = 0; is_chk[o] = 0;
      end
      is_chk[kill_off] = 0;
      len = kill_off + 3;
    end
    cnt = 0;
    for (int o = 1; o < len; o++) begin
      e_iter[o] = ITER_W'(cnt);
      if (killed && kill_rst && o > kill_off) e_iter[o] = '0;
      if (is_chk[o]) cnt++;
      exp_q.push_back({e_en[o], e_busy[o], e_done[o], e_err[o], e_estg[o], e_iter[o]});
    end

    for (int o = 0; o < len; o++) begin
      @(negedge clk);
      if (o > 0) begin
        w = exp_q.pop_front();
        chk("stage_en", 32'(stage_en), 32'(w[W-1 -: N_STAGE]));
        chk("busy",     32'(busy),     32'(w[ITER_W+4]));
        chk("done",     32'(done),     32'(w[ITER_W+3]));
        chk("err",      32'(err),      32'(w[ITER_W+2]));
        chk("iter_cnt", 32'(iter_cnt), 32'(w[ITER_W-1:0]));
        if (w[ITER_W+2]) chk("err_stage", 32'(err_stage), 32'(w[ITER_W+1 -: 2]));
      end
      nz = noisy ? N_STAGE'($urandom_range(15, 0) & $urandom_range(15, 0)) : '0;
      stage_done = d_done[o] | (nz & ~wait_mask[o]);
      converged  = conv_fix[o] ? d_conv[o] : (noisy ? 1'($urandom_range(1, 0)) : 1'b0);
      max_iter   = (o == 0) ? ITER_W'(lim) : ITER_W'($urandom_range(255, 0));
      start      = (o == 0) ||
                   (noisy && (e_busy[o] || e_done[o]) && (!killed || o < kill_off) &&
                    ($urandom_range(7, 0) == 0));
      abort      = killed && !kill_rst && (o == kill_off);
      rst_n      = !(killed && kill_rst && (o == kill_off));
    end
    if (killed && kill_rst) chk("rst_err_stage", 32'(err_stage), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; converged = 1'b0;
    max_iter = '0; stage_done = '0;
    repeat (3) @(negedge clk);
    chk("rst_stage_en",  32'(stage_en),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_iter_cnt",  32'(iter_cnt),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_err_stage", 32'(err_stage), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // three full iterations, one-cycle stage latency, done at start+28
    run_case(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // convergence on iteration 2 ends the run early; noise on other inputs
    run_case(10, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    // stage 2 never answers: error 64 cycles after its enable
    run_case(2, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
    // restart out of ERR
    run_case(2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1);
    // abort while waiting on stage 1 of iteration 2
    run_case(4, 0, 1, 1, 0, 0, 0, 0, 13, 0, 0);
    // max_iter = 0 runs once; start pulses while busy are ignored
    run_case(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    // completion on the watchdog's last cycle wins over the error
    run_case(1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    // synchronous reset in the middle of a run
    run_case(3, 0, 1, 2, 0, 0, 0, 0, 15, 1, 1);

    for (int r = 0; r < 25; r++) begin
      int hi, hs, si, ss, ko;
      hi = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      hs = $urandom_range(3, 0);
      si = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      ss = $urandom_range(3, 0);
      ko = ($urandom_range(3, 0) == 0) ? int'($urandom_range(80, 1)) : 0;
      run_case($urandom_range(5, 0), $urandom_range(6, 0), 1, 4, hi, hs, si, ss,
               ko, 1'($urandom_range(1, 0)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
